// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared UART constants and transmit state encoding       |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, async reset, show-ahead read port   |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int                 c_PTR_W    = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL_CNT = DEPTH[c_PTR_W:0];

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == c_FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Guarded here so callers can never overrun or underrun the queue
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_buffered : FIFO-buffered 8N1 UART transmitter, LSB first   |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    wr_data_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int                          c_BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                          c_BIT_W     = $clog2(UART_DATA_BITS);
  localparam logic [c_BAUD_W-1:0]         c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0]          c_LAST_BIT  = c_BIT_W'(UART_DATA_BITS - 1);

  tx_state_t                     r_state;
  logic                          r_tx;
  logic [UART_DATA_BITS-1:0]     r_shift;
  logic [c_BIT_W-1:0]            r_bit_cnt;
  logic [c_BAUD_W-1:0]           r_baud_cnt;

  logic [7:0]                    w_fifo_data;
  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  logic                          w_baud_last;
  logic                          w_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (wr_valid_i),
    .i_pop   (w_pop),
    .i_data  (wr_data_i),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (fifo_count_o)
  );

  assign w_baud_last = (r_baud_cnt == c_BAUD_LAST);
  // A new frame is popped from IDLE, or straight out of the last STOP cycle for gapless streaming
  assign w_pop       = !w_fifo_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_last));

  assign wr_ready_o  = !w_fifo_full;
  assign tx_o        = r_tx;
  assign busy_o      = (r_state != ST_IDLE) || (fifo_count_o != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_state    <= ST_START;
            r_shift    <= w_fifo_data;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b0;
          end
        end
        ST_START: begin
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            r_state    <= ST_DATA;
            r_tx       <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == c_LAST_BIT) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            if (!w_fifo_empty) begin
              r_state   <= ST_START;
              r_shift   <= w_fifo_data;
              r_bit_cnt <= '0;
              r_tx      <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx_buffered : self-checking bench for uart_tx_buffered     |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_uart_tx_buffered;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // expected bit-centre samples, bit 0 = start bit
  } frame_vec_t;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_data_i    (wr_data),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .tx_o         (tx),
    .busy_o       (busy),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a byte queue plus the remaining length of the frame on the wire
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_cur  = 8'h00;
  int         m_left = 0;
  bit         m_take = 1'b0;
  bit         m_acc  = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_q.delete();
      m_left = 0;
      m_acc  = 1'b0;
    end else begin
      m_take = wr_valid && (m_q.size() < DEPTH);
      if (m_left <= 1) begin
        if (m_q.size() != 0) begin
          m_cur  = m_q.pop_front();
          m_left = FRAME;
        end else begin
          m_left = 0;
        end
      end else begin
        m_left--;
      end
      if (m_take) begin
        m_q.push_back(wr_data);
        m_sent.push_back(wr_data);
      end
      m_acc = m_take;
    end
  end

  function automatic logic exp_tx();
    int b;
    if (m_left == 0) return 1'b1;
    b = (FRAME - m_left) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  bit chk_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("tx_known",   32'($isunknown(tx)), 32'd0);
      chk("tx_line",    32'(tx),             32'(exp_tx()));
      chk("wr_ready",   32'(wr_ready),       32'(m_q.size() < DEPTH));
      chk("busy",       32'(busy),           32'((m_left != 0) || (m_q.size() != 0)));
      chk("fifo_count", 32'(fifo_count),     32'(m_q.size()));
    end
  end

  // Independent line receiver sampling at bit centres
  bit         rx_en = 1'b0;
  logic [7:0] rx_q[$];
  initial begin
    logic       prev;
    logic [7:0] d;
    prev = 1'b1;
    d    = 8'h00;
    forever begin
      @(negedge clk);
      if (rx_en && prev === 1'b1 && tx === 1'b0) begin
        repeat (CPB/2 - 1) @(negedge clk);
        chk("rx_start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        chk("rx_stop_bit", 32'(tx), 32'd1);
        rx_q.push_back(d);
      end
      prev = tx;
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    frame_vec_t vecs[4];
    logic [7:0] burst[5];
    int         t;
    int         n;
    int         cyc;
    int         gap;

    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    burst   = '{8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h81};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_tx",    32'(tx),         32'd1);
    chk("rst_ready", 32'(wr_ready),   32'd1);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;

    // Quiet line after reset release
    repeat (200) @(negedge clk);
    chk("quiet_tx",    32'(tx),         32'd1);
    chk("quiet_busy",  32'(busy),       32'd0);
    chk("quiet_ready", 32'(wr_ready),   32'd1);
    chk("quiet_count", 32'(fifo_count), 32'd0);

    // Single frames against hand-derived line patterns
    foreach (vecs[v]) begin
      push_byte(vecs[v].data);
      @(negedge clk);
      chk("start_latency", 32'(tx), 32'd0);
      t = 0;
      for (int k = 0; k < 10; k++) begin
        repeat (CPB*k + CPB/2 - t) @(negedge clk);
        t = CPB*k + CPB/2;
        chk($sformatf("bit%0d_of_%02h", k, vecs[v].data), 32'(tx), 32'(vecs[v].line[k]));
      end
      repeat (FRAME - 1 - t) @(negedge clk);
      chk("busy_last_cycle", 32'(busy), 32'd1);
      @(negedge clk);
      chk("idle_after_frame", 32'(busy), 32'd0);
    end

    // Burst fills the FIFO; sixth byte is refused; frames run back to back
    foreach (burst[i]) begin
      wr_valid = 1'b1;
      wr_data  = burst[i];
      @(negedge clk);
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(wr_ready),   32'd0);
    wr_data = 8'hEE;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("refused_count", 32'(fifo_count), 32'd4);
    cyc = 0;
    while (busy !== 1'b0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("burst_duration", 32'(cyc), 32'(5*FRAME - 4));

    // Valid held against a full FIFO is taken on the edge after the first pop
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h11 * (i + 1));
      @(negedge clk);
    end
    wr_data = 8'h66;
    cyc = 0;
    while (wr_ready !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("pop_to_ready", 32'(cyc), 32'(FRAME - 3));
    chk("after_pop_count", 32'(fifo_count), 32'd3);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("held_accept_count", 32'(fifo_count), 32'd4);
    chk("held_accept_ready", 32'(wr_ready),   32'd0);
    wait_idle("hold_drain");

    // Asynchronous reset in the middle of data bit 3
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = (i == 0) ? 8'h55 : 8'(8'hA0 + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    repeat (69) @(negedge clk);
    chk("abort_pre_tx",    32'(tx),         32'd0);
    chk("abort_pre_count", 32'(fifo_count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx",    32'(tx),         32'd1);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_busy",  32'(busy),       32'd0);
    chk("abort_ready", 32'(wr_ready),   32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    chk("post_abort_busy", 32'(busy), 32'd0);
    chk("post_abort_tx",   32'(tx),   32'd1);

    // Random traffic decoded by the line receiver
    m_sent.delete();
    rx_q.delete();
    rx_en = 1'b1;
    n   = 0;
    gap = 0;
    cyc = 0;
    while (n < 200 && cyc < 60000) begin
      if (wr_valid && m_acc) begin
        n++;
        wr_valid = 1'b0;
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 250)) : 0;
      end
      if (!wr_valid && n < 200) begin
        if (gap == 0) begin
          wr_valid = 1'b1;
          wr_data  = 8'($urandom);
        end else begin
          gap--;
        end
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0;
    chk("random_accepted", 32'(n), 32'd200);
    wait_idle("random_drain");
    repeat (20) @(negedge clk);
    rx_en = 1'b0;
    chk("rx_count", 32'(rx_q.size()), 32'(m_sent.size()));
    for (int i = 0; i < m_sent.size() && i < rx_q.size(); i++) begin
      chk($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(m_sent[i]));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
